// File: rtl/pipeline.sv
// Three-stage elastic datapath: data_out = ((data_in + 1) << 1) mod 2^DATA_WIDTH.
// Latency: a word accepted at edge E0 reaches S2 at E1 and appears with DOR=1 after E2.
// Backpressure: stalled stages hold their contents; the input is refused while S1 cannot load.
module pipeline #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  DIR,
  input  logic                  ack_to_pipeline,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  DOR,
  output logic                  ack_from_pipeline,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic                  s1_vld;
  logic                  s2_vld;
  logic [DATA_WIDTH-1:0] s1_dat;
  logic [DATA_WIDTH-1:0] s2_dat;
  logic                  armed;
  logic                  s3_load;
  logic                  s2_load;
  logic                  s1_can_load;
  logic                  accept;

  // Load chain, resolved from the output backwards so that a stage being emptied can refill on the same edge.
  always_comb begin
    s3_load     = s2_vld && (!DOR || ack_to_pipeline);
    s2_load     = s1_vld && (!s2_vld || s3_load);
    s1_can_load = !s1_vld || s2_load;
    accept      = DIR && armed && s1_can_load;
  end

  // Input handshake: a single acceptance per DIR assertion, re-armed whenever DIR is seen low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed             <= 1'b1;
      ack_from_pipeline <= 1'b0;
    end else begin
      ack_from_pipeline <= accept;
      if (accept) begin
        armed <= 1'b0;
      end else if (!DIR) begin
        armed <= 1'b1;
      end
    end
  end

  // Stage 1: capture the incremented input word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      if (accept) begin
        s1_vld <= 1'b1;
        s1_dat <= data_in + ONE;
      end else if (s2_load) begin
        s1_vld <= 1'b0;
      end
    end
  end

  // Stage 2: doubled value of stage 1, held while stage 3 is blocked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else begin
      if (s2_load) begin
        s2_vld <= 1'b1;
        s2_dat <= {s1_dat[DATA_WIDTH-2:0], 1'b0};
      end else if (s3_load) begin
        s2_vld <= 1'b0;
      end
    end
  end

  // Stage 3: output register; data_out never changes while an unconsumed word is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DOR      <= 1'b0;
      data_out <= '0;
    end else begin
      if (s3_load) begin
        DOR      <= 1'b1;
        data_out <= s2_dat;
      end else if (DOR && ack_to_pipeline) begin
        DOR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline.sv
// Directed bench for pipeline with a scoreboard of expected results.
// Latency: expected words are queued when offered and compared when consumed.
// Backpressure: downstream acknowledge is withheld in places to fill the pipe.
module tb_pipeline;

  logic       clk;
  logic       reset;
  logic       DIR;
  logic       ack_to_pipeline;
  logic [7:0] data_in;
  logic       DOR;
  logic       ack_from_pipeline;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;
  int pulses;
  logic [7:0] exp_q[$];

  pipeline #(.DATA_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .DIR               (DIR),
    .ack_to_pipeline   (ack_to_pipeline),
    .data_in           (data_in),
    .DOR               (DOR),
    .ack_from_pipeline (ack_from_pipeline),
    .data_out          (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] w);
    logic [8:0] t;
    t = ({1'b0, w} + 9'd1) * 9'd2;
    return t[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one word as a one-cycle DIR pulse, then drop DIR for a cycle to re-arm.
  task automatic offer(input string tag, input logic [7:0] w, input int exp_ack);
    data_in = w;
    DIR     = 1'b1;
    tick();
    check({tag, "_ack"}, int'(ack_from_pipeline), exp_ack);
    DIR = 1'b0;
    tick();
    check({tag, "_ack_pulse_end"}, int'(ack_from_pipeline), 0);
  endtask

  // Consume every queued result in order, counting input acknowledges seen meanwhile.
  task automatic drain(input string tag, output int n_ack);
    int budget;
    budget = 0;
    n_ack  = 0;
    while (exp_q.size() > 0 && budget < 60) begin
      if (DOR) begin
        check({tag, "_data"}, int'(data_out), int'(exp_q.pop_front()));
        ack_to_pipeline = 1'b1;
      end else begin
        ack_to_pipeline = 1'b0;
      end
      tick();
      if (ack_from_pipeline) n_ack++;
      budget++;
    end
    ack_to_pipeline = 1'b0;
    check({tag, "_left_in_queue"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset           = 1'b0;
    DIR             = 1'b1;
    ack_to_pipeline = 1'b0;
    data_in         = 8'd42;

    // Reset held with a pending request: nothing is accepted.
    repeat (3) tick();
    check("rst_dor", int'(DOR), 0);
    check("rst_ack", int'(ack_from_pipeline), 0);
    check("rst_data", int'(data_out), 0);

    // Single word, DIR held for three cycles after release.
    reset = 1'b1;
    tick();
    check("single_ack", int'(ack_from_pipeline), 1);
    tick();
    check("single_ack_once", int'(ack_from_pipeline), 0);
    check("single_dor_early", int'(DOR), 0);
    tick();
    check("single_ack_still_once", int'(ack_from_pipeline), 0);
    check("single_dor", int'(DOR), 1);
    check("single_data", int'(data_out), int'(model(8'd42)));
    DIR = 1'b0;
    tick();
    check("single_dor_hold", int'(DOR), 1);
    check("single_data_hold", int'(data_out), 86);
    ack_to_pipeline = 1'b1;
    tick();
    check("single_consumed", int'(DOR), 0);
    ack_to_pipeline = 1'b0;
    repeat (3) begin
      tick();
      check("single_no_second_dor", int'(DOR), 0);
      check("single_no_second_ack", int'(ack_from_pipeline), 0);
    end

    // Arithmetic wrap.
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd146);
    offer("wrap255", 8'd255, 1);
    offer("wrap127", 8'd127, 1);
    offer("wrap200", 8'd200, 1);
    drain("wrap", pulses);
    check("wrap_extra_accepts", pulses, 0);

    // Acknowledge while empty is ignored.
    ack_to_pipeline = 1'b1;
    repeat (2) tick();
    check("empty_ack_dor", int'(DOR), 0);
    ack_to_pipeline = 1'b0;

    // Backpressure: three words fill the pipe, the fourth stays pending.
    offer("bp1", 8'd1, 1);
    offer("bp2", 8'd2, 1);
    offer("bp3", 8'd3, 1);
    exp_q.push_back(model(8'd1));
    exp_q.push_back(model(8'd2));
    exp_q.push_back(model(8'd3));
    exp_q.push_back(model(8'd4));
    data_in = 8'd4;
    DIR     = 1'b1;
    repeat (4) begin
      tick();
      check("bp4_pending_no_ack", int'(ack_from_pipeline), 0);
      check("bp_dor_held", int'(DOR), 1);
      check("bp_data_stable", int'(data_out), 4);
    end
    drain("bp", pulses);
    check("bp4_accepted_once", pulses, 1);
    DIR = 1'b0;
    repeat (3) begin
      tick();
      check("bp_no_extra_output", int'(DOR), 0);
    end

    // Reset while a word is in flight: it never emerges.
    data_in = 8'd42;
    DIR     = 1'b1;
    tick();
    check("mid_ack", int'(ack_from_pipeline), 1);
    reset = 1'b0;
    DIR   = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) begin
      tick();
      check("mid_dor", int'(DOR), 0);
    end
    check("mid_data", int'(data_out), 0);

    // Full pipe with consume and accept on the same edge.
    offer("fe10", 8'd10, 1);
    offer("fe20", 8'd20, 1);
    offer("fe30", 8'd30, 1);
    exp_q.push_back(8'd22);
    exp_q.push_back(8'd42);
    exp_q.push_back(8'd62);
    exp_q.push_back(8'd82);
    data_in = 8'd40;
    DIR     = 1'b1;
    drain("full_edge", pulses);
    check("full_edge_accepted_once", pulses, 1);
    DIR = 1'b0;
    repeat (3) begin
      tick();
      check("full_edge_no_dup", int'(DOR), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
